// File: rtl/rf_pkg.sv
// Shared definitions for the register file with busy scoreboard.
// Holds the default geometry, the address-width derivation and the
// scoreboard vector type for the default depth.
package rf_pkg;

  localparam int RF_WIDTH_DEF = 8;
  localparam int RF_DEPTH_DEF = 16;

  // Address width for a given register count; never narrower than one bit.
  function automatic int rf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [RF_DEPTH_DEF-1:0] rf_busy_vec_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   wr_en_i, wa_i     : qualified write-back (already excludes the zero register)
//   claim_en_i,
//   claim_addr_i      : claim request and its target register
//   ra1_i, ra2_i      : read addresses whose raw busy bits are reported
//   busy1_o, busy2_o  : raw busy bits for ra1_i / ra2_i (no forwarding)
//   claim_ok_o        : claim accepted this cycle
//   busy_count_o      : registered number of busy bits set
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = rf_addr_w(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wa_i,
  input  logic          claim_en_i,
  input  logic [AW-1:0] claim_addr_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic          busy1_o,
  output logic          busy2_o,
  output logic          claim_ok_o,
  output logic [CW-1:0] busy_count_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             claim_set;
  logic             rel_clr;

  always_comb begin
    claim_ok_o = claim_en_i && !busy_q[claim_addr_i];
    // The zero register acknowledges a claim but never records it.
    claim_set  = claim_ok_o && !(ZERO_REG && (claim_addr_i == '0));
    // A release only counts when it clears a set bit. If the same register
    // is also being claimed, its bit is clear (else the claim is rejected),
    // so set and clear never target the same bit at once.
    rel_clr    = wr_en_i && busy_q[wa_i];

    busy_d = busy_q;
    if (rel_clr)   busy_d[wa_i]         = 1'b0;
    // Applied after the release so that a claim wins on the same register.
    if (claim_set) busy_d[claim_addr_i] = 1'b1;

    cnt_d = cnt_q;
    if (claim_set && !rel_clr)      cnt_d = cnt_q + CW'(1);
    else if (!claim_set && rel_clr) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy1_o      = busy_q[ra1_i];
  assign busy2_o      = busy_q[ra2_i];
  assign busy_count_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired zero register and a
// per-register busy scoreboard for multi-cycle operations.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   RA1, RA2               : read addresses
//   WA, data_in,
//   write_enable           : write port; a write also releases busy[WA]
//   claim_en, claim_addr   : claim a destination register as busy
//   data_out1, data_out2   : read data
//   busy1, busy2           : read register has an outstanding claim
//   claim_ok               : claim accepted this cycle
//   busy_count             : number of busy registers
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = rf_addr_w(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_enable,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic             busy1,
  output logic             busy2,
  output logic             claim_ok,
  output logic [CW-1:0]    busy_count
);

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic             wr_legal;
  logic             byp1, byp2;
  logic             sb_busy1, sb_busy2;

  // Writes to the hardwired zero register are dropped entirely.
  assign wr_legal = write_enable && !(ZERO_REG && (WA == '0));
  assign byp1     = BYPASS && wr_legal && (WA == RA1);
  assign byp2     = BYPASS && wr_legal && (WA == RA2);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (wr_legal) begin
      rf_q[WA] <= data_in;
    end
  end

  // Zero register overrides the bypass, which overrides stored data.
  always_comb begin
    data_out1 = rf_q[RA1];
    if (byp1) data_out1 = data_in;
    if (ZERO_REG && (RA1 == '0)) data_out1 = '0;

    data_out2 = rf_q[RA2];
    if (byp2) data_out2 = data_in;
    if (ZERO_REG && (RA2 == '0)) data_out2 = '0;
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (wr_legal),
    .wa_i         (WA),
    .claim_en_i   (claim_en),
    .claim_addr_i (claim_addr),
    .ra1_i        (RA1),
    .ra2_i        (RA2),
    .busy1_o      (sb_busy1),
    .busy2_o      (sb_busy2),
    .claim_ok_o   (claim_ok),
    .busy_count_o (busy_count)
  );

  // A write-back landing this cycle resolves the hazard for a forwarded read.
  assign busy1 = sb_busy1 && !byp1;
  assign busy2 = sb_busy2 && !byp2;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int CW = 5;

  localparam int S_DO1A = 0;
  localparam int S_DO2A = 1;
  localparam int S_B1A  = 2;
  localparam int S_B2A  = 3;
  localparam int S_COKA = 4;
  localparam int S_CNTA = 5;
  localparam int S_DO1B = 6;
  localparam int S_DO2B = 7;
  localparam int S_B1B  = 8;
  localparam int S_B2B  = 9;
  localparam int S_COKB = 10;
  localparam int S_CNTB = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] ra1, ra2, wa, caddr;
  logic [W-1:0]  din;
  logic          we, cen;

  logic [W-1:0]  do1_a, do2_a, do1_b, do2_b;
  logic          b1_a, b2_a, cok_a, b1_b, b2_b, cok_b;
  logic [CW-1:0] cnt_a, cnt_b;

  // Instance A: bypass on, no zero register.
  reg_file_sb u_dut_a (
    .clk(clk), .reset(rst), .RA1(ra1), .RA2(ra2), .WA(wa), .data_in(din),
    .write_enable(we), .claim_en(cen), .claim_addr(caddr),
    .data_out1(do1_a), .data_out2(do2_a), .busy1(b1_a), .busy2(b2_a),
    .claim_ok(cok_a), .busy_count(cnt_a)
  );

  // Instance B: zero register on, bypass off.
  reg_file_sb #(.ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_b (
    .clk(clk), .reset(rst), .RA1(ra1), .RA2(ra2), .WA(wa), .data_in(din),
    .write_enable(we), .claim_en(cen), .claim_addr(caddr),
    .data_out1(do1_b), .data_out2(do2_b), .busy1(b1_b), .busy2(b2_b),
    .claim_ok(cok_b), .busy_count(cnt_b)
  );

  typedef struct {
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(input int s);
    case (s)
      S_DO1A:  return 32'(do1_a);
      S_DO2A:  return 32'(do2_a);
      S_B1A:   return 32'(b1_a);
      S_B2A:   return 32'(b2_a);
      S_COKA:  return 32'(cok_a);
      S_CNTA:  return 32'(cnt_a);
      S_DO1B:  return 32'(do1_b);
      S_DO2B:  return 32'(do2_b);
      S_B1B:   return 32'(b1_b);
      S_B2B:   return 32'(b2_b);
      S_COKB:  return 32'(cok_b);
      S_CNTB:  return 32'(cnt_b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sname(input int s);
    case (s)
      S_DO1A:  return "data_out1_a";
      S_DO2A:  return "data_out2_a";
      S_B1A:   return "busy1_a";
      S_B2A:   return "busy2_a";
      S_COKA:  return "claim_ok_a";
      S_CNTA:  return "busy_count_a";
      S_DO1B:  return "data_out1_b";
      S_DO2B:  return "data_out2_b";
      S_B1B:   return "busy1_b";
      S_B2B:   return "busy2_b";
      S_COKB:  return "claim_ok_b";
      S_CNTB:  return "busy_count_b";
      default: return "unknown";
    endcase
  endfunction

  task automatic drive(input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] w, input logic [W-1:0] d, input logic e,
                       input logic c, input logic [AW-1:0] ca);
    @(negedge clk);
    rst = r; ra1 = a1; ra2 = a2; wa = w; din = d; we = e; cen = c; caddr = ca;
  endtask

  task automatic push_exp(input int s, input logic [31:0] v);
    sb.push_back('{sel: s, val: v});
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] o;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", sname(e.sel), o, e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ra1 = '0; ra2 = '0; wa = '0; din = '0; we = 1'b0; cen = 1'b0; caddr = '0;

    // Reset cycle with a write and claim that must be discarded.
    drive(1, 0, 0, 1, 8'h77, 1, 1, 1);

    // Post-reset sweep of all addresses.
    for (int i = 0; i < 16; i++) begin
      drive(0, AW'(i), AW'(15 - i), 0, 0, 0, 0, 0);
      push_exp(S_DO1A, 0); push_exp(S_DO2A, 0); push_exp(S_B1A, 0); push_exp(S_B2A, 0);
      push_exp(S_DO1B, 0); push_exp(S_DO2B, 0); push_exp(S_B1B, 0); push_exp(S_B2B, 0);
      push_exp(S_CNTA, 0); push_exp(S_CNTB, 0);
      check_all();
    end

    // Write r3 then read it back.
    drive(0, 0, 0, 3, 8'hA5, 1, 0, 0);
    drive(0, 3, 0, 0, 0, 0, 0, 0);
    push_exp(S_DO1A, 8'hA5); push_exp(S_DO1B, 8'hA5);
    check_all();

    // Same-cycle write/read of r5: forwarded on A, old value on B.
    drive(0, 0, 5, 5, 8'h3C, 1, 0, 0);
    push_exp(S_DO2A, 8'h3C); push_exp(S_DO2B, 8'h00); push_exp(S_B2A, 0);
    check_all();
    drive(0, 0, 5, 0, 0, 0, 0, 0);
    push_exp(S_DO2A, 8'h3C); push_exp(S_DO2B, 8'h3C);
    check_all();

    // Write 0xFF to r0 and claim r0.
    drive(0, 0, 0, 0, 8'hFF, 1, 1, 0);
    push_exp(S_DO1B, 0); push_exp(S_B1B, 0); push_exp(S_COKB, 1);
    push_exp(S_DO1A, 8'hFF); push_exp(S_COKA, 1);
    check_all();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push_exp(S_DO1B, 0); push_exp(S_B1B, 0); push_exp(S_CNTB, 0);
    push_exp(S_DO1A, 8'hFF); push_exp(S_B1A, 1); push_exp(S_CNTA, 1);
    check_all();
    // Release r0 on A.
    drive(0, 0, 0, 0, 8'h00, 1, 0, 0);
    push_exp(S_B1A, 0); push_exp(S_DO1A, 0); push_exp(S_CNTA, 1);
    check_all();

    // Claim r7, re-claim rejected, write-back releases it.
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    push_exp(S_COKA, 1); push_exp(S_COKB, 1); push_exp(S_CNTA, 0);
    check_all();
    drive(0, 7, 0, 0, 0, 0, 1, 7);
    push_exp(S_B1A, 1); push_exp(S_B1B, 1); push_exp(S_CNTA, 1); push_exp(S_CNTB, 1);
    push_exp(S_COKA, 0); push_exp(S_COKB, 0);
    check_all();
    drive(0, 7, 0, 7, 8'h11, 1, 0, 0);
    push_exp(S_B1A, 0); push_exp(S_DO1A, 8'h11); push_exp(S_B1B, 1); push_exp(S_DO1B, 0);
    push_exp(S_CNTA, 1);
    check_all();
    drive(0, 7, 0, 0, 0, 0, 0, 0);
    push_exp(S_B1A, 0); push_exp(S_B1B, 0); push_exp(S_CNTA, 0); push_exp(S_CNTB, 0);
    push_exp(S_DO1A, 8'h11); push_exp(S_DO1B, 8'h11);
    check_all();

    // Same-cycle write and claim of r2, busy clear: claim wins.
    drive(0, 2, 0, 2, 8'h42, 1, 1, 2);
    push_exp(S_COKA, 1); push_exp(S_COKB, 1);
    check_all();
    drive(0, 2, 0, 0, 0, 0, 0, 0);
    push_exp(S_DO1A, 8'h42); push_exp(S_DO1B, 8'h42); push_exp(S_B1A, 1); push_exp(S_B1B, 1);
    push_exp(S_CNTA, 1); push_exp(S_CNTB, 1);
    check_all();
    // Same-cycle write and claim of r2, busy set: claim rejected, busy cleared.
    drive(0, 2, 0, 2, 8'h43, 1, 1, 2);
    push_exp(S_COKA, 0); push_exp(S_COKB, 0); push_exp(S_B1A, 0); push_exp(S_B1B, 1);
    check_all();
    drive(0, 2, 0, 0, 0, 0, 0, 0);
    push_exp(S_B1A, 0); push_exp(S_B1B, 0); push_exp(S_CNTA, 0); push_exp(S_CNTB, 0);
    push_exp(S_DO1A, 8'h43); push_exp(S_DO1B, 8'h43);
    check_all();

    // Re-claim r2, then reset mid-operation.
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    push_exp(S_COKA, 1);
    check_all();
    drive(1, 2, 4, 4, 8'h99, 1, 1, 4);
    push_exp(S_CNTA, 1); push_exp(S_B1A, 1);
    check_all();
    drive(0, 2, 4, 0, 0, 0, 0, 0);
    push_exp(S_DO1A, 0); push_exp(S_DO2A, 0); push_exp(S_CNTA, 0); push_exp(S_CNTB, 0);
    push_exp(S_B1A, 0); push_exp(S_B2A, 0); push_exp(S_DO2B, 0);
    check_all();
    // Late write-back after reset just writes data.
    drive(0, 0, 0, 2, 8'h55, 1, 0, 0);
    drive(0, 2, 0, 0, 0, 0, 0, 0);
    push_exp(S_DO1A, 8'h55); push_exp(S_DO1B, 8'h55); push_exp(S_CNTA, 0); push_exp(S_B1A, 0);
    check_all();

    // Claim every register: count saturates at DEPTH (A) and DEPTH-1 (B).
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, AW'(i));
      push_exp(S_COKA, 1); push_exp(S_COKB, 1);
      push_exp(S_CNTA, 32'(i)); push_exp(S_CNTB, (i == 0) ? 0 : 32'(i - 1));
      check_all();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    push_exp(S_CNTA, 16); push_exp(S_CNTB, 15); push_exp(S_COKA, 0); push_exp(S_COKB, 0);
    check_all();

    // Release every register by write-back.
    for (int i = 0; i < 16; i++) begin
      drive(0, AW'(i), 0, AW'(i), W'(i), 1, 0, 0);
      push_exp(S_B1A, 0); push_exp(S_B1B, (i == 0) ? 0 : 1);
      push_exp(S_CNTA, 32'(16 - i)); push_exp(S_CNTB, (i == 0) ? 15 : 32'(16 - i));
      check_all();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push_exp(S_CNTA, 0); push_exp(S_CNTB, 0); push_exp(S_DO1B, 0);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the 16-bit RISC datapath: two combinational read ports, one write port, write-to-read bypass and an optional hardwired zero register.
- Adds a per-register busy scoreboard for multi-cycle ops: a destination is claimed at issue and released by its write-back, so the control unit can stall on RAW hazards.
- Sits between decode/control and the ALU, replacing the fixed 16x8 register file.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 16, number of registers (power of two, >=2); AW = $clog2(DEPTH).
- ZERO_REG, 0, if 1 register 0 always reads 0, ignores writes and cannot be claimed.
- BYPASS, 1, if 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, clk.
- RA1  in  AW  read address, port 1.
- RA2  in  AW  read address, port 2.
- WA  in  AW  write address.
- data_in  in  WIDTH  write data.
- write_enable  in  1  commit data_in to rf[WA]; also releases busy[WA].
- claim_en  in  1  request to mark claim_addr busy.
- claim_addr  in  AW  register being claimed.
- data_out1  out  WIDTH  read data, port 1.
- data_out2  out  WIDTH  read data, port 2.
- busy1  out  1  RA1 has an outstanding claim.
- busy2  out  1  RA2 has an outstanding claim.
- claim_ok  out  1  claim is accepted this cycle.
- busy_count  out  $clog2(DEPTH+1)  number of set busy bits.

Behaviour:
- Reset (synchronous, priority over everything): all rf entries = 0, all busy bits = 0, busy_count = 0. Writes and claims in the reset cycle are discarded. After reset all data_out* = 0, busy* = 0, and claim_ok is 1 for any address.
- Write: on posedge, if write_enable and not (ZERO_REG and WA==0), then rf[WA] <= data_in and busy[WA] <= 0.
- Read: combinational, zero latency.
  - data_outN = rf[RAN].
  - If BYPASS, write_enable, WA==RAN and the write is legal, data_outN = data_in.
  - If ZERO_REG and RAN==0, data_outN = 0, overriding the bypass.
- busyN = busy[RAN], and 0 when the bypass condition for port N holds. Without BYPASS, busyN = busy[RAN] with no forwarding.
- claim_ok = claim_en and not busy[claim_addr].
  - A claim on an already-busy register is rejected, leaving state unchanged.
  - If ZERO_REG and claim_addr==0, claim_ok = claim_en but no bit is set.
- Claim: on posedge, if claim_ok (and not the zero register), busy[claim_addr] <= 1.
- Simultaneous write and claim, same address, busy=0: data is written and busy ends at 1 (claim wins over release).
- Simultaneous write and claim, same address, busy=1: claim is rejected and busy is cleared.
- Write to a non-busy register is legal and leaves busy at 0.
- busy_count is a registered counter, updated each edge by (+1 if a bit is set) and (-1 if a set bit is cleared). The net change is in {-1, 0, +1}. It never wraps: max DEPTH (DEPTH-1 if ZERO_REG), min 0.
- Reset mid-operation clears all outstanding claims; pending write-backs after reset simply write data.

Decomposition:
- Shared package rf_pkg holds the WIDTH/DEPTH defaults, the AW derivation function, and a typedef for the scoreboard vector.
- One natural sub-module, rf_scoreboard: the busy vector, claim_ok logic and busy_count.
- The storage array and bypass muxes stay in the top module.

Test Plan:
- Reset then read all addresses -> every data_out = 0, busy1 = busy2 = 0, busy_count = 0.
- Write 0xA5 to r3, then the next cycle RA1=3 -> data_out1 = 0xA5.
- Same-cycle write 0x3C to r5 with RA2=5 -> data_out2 = 0x3C with BYPASS=1, old value with BYPASS=0.
- ZERO_REG=1: write 0xFF to r0 and claim r0 -> data_out1 = 0, busy1 = 0, busy_count = 0.
- Claim r7 -> next cycle busy1 = 1 (RA1=7), busy_count = 1, a second claim of r7 gives claim_ok = 0; write r7 = 0x11 -> busy1 = 0 that same cycle (bypass), busy_count = 0 after the edge.
- Claim r2 while writing r2 = 0x42 in the same cycle, busy=0 -> rf[2] = 0x42, busy[2] = 1, busy_count = 1; then assert reset -> busy_count = 0, rf[2] = 0.
